// File: rtl/led_anim_sched.sv
// Arbitrated animation scheduler for the 8-LED bar: HIT > SWEEP > CHARGE, stepped every 2^TICK_DIV clocks.
// Optional: define LED_SCHED_PREEMPT_EN to let a HIT request abort a running CHARGE/SWEEP on a tick.
module led_anim_sched #(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       done,
    output logic [7:0] led
);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    localparam logic [TICK_DIV-1:0] CNT_ONE = TICK_DIV'(1);
    localparam logic [2:0] GNT_CHARGE = 3'b001;
    localparam logic [2:0] GNT_HIT    = 3'b010;
    localparam logic [2:0] GNT_SWEEP  = 3'b100;

    state_t              state_reg;
    logic [TICK_DIV-1:0] cnt_reg;
    logic [3:0]          step_reg;
    logic [2:0]          gnt_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [7:0]          led_reg;

    logic                tick;
    logic                preempt;
    logic [2:0]          req_sel;
    logic [3:0]          last_step;
    logic [2:0]          pat_gnt;
    logic [3:0]          pat_step;
    logic [4:0]          charge_k;
    logic [2:0]          sweep_p;
    logic                hit_on;
    logic [7:0]          pat_led;

    assign tick = &cnt_reg;

    always_comb begin
        req_sel = 3'b000;
        if (req[1])
            req_sel = GNT_HIT;
        else if (req[2])
            req_sel = GNT_SWEEP;
        else if (req[0])
            req_sel = GNT_CHARGE;
    end

    always_comb begin
        case (gnt_reg)
            GNT_HIT:   last_step = 4'd7;
            GNT_SWEEP: last_step = 4'd13;
            default:   last_step = 4'd15;
        endcase
    end

`ifdef LED_SCHED_PREEMPT_EN
    assign preempt = (state_reg == RUN) && tick && req[1] && !gnt_reg[1];
`else
    assign preempt = 1'b0;
`endif

    // The LED register is loaded with the pattern of whatever grant/step becomes current next.
    always_comb begin
        pat_gnt  = gnt_reg;
        pat_step = step_reg + 4'd1;
        if (preempt) begin
            pat_gnt  = GNT_HIT;
            pat_step = 4'd0;
        end else if (state_reg == IDLE) begin
            pat_gnt  = req_sel;
            pat_step = 4'd0;
        end
    end

    assign charge_k = pat_step[3] ? 5'(5'd16 - {1'b0, pat_step}) : 5'({1'b0, pat_step} + 5'd1);
    assign sweep_p  = pat_step[3] ? 3'(4'd14 - pat_step) : pat_step[2:0];
    assign hit_on   = ~pat_step[0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pat
            logic charge_bit;
            logic sweep_bit;
            assign charge_bit  = (5'(gi) + charge_k) >= 5'd8;
            assign sweep_bit   = (sweep_p == 3'(gi));
            assign pat_led[gi] = (pat_gnt[0] & charge_bit) |
                                 (pat_gnt[1] & hit_on)     |
                                 (pat_gnt[2] & sweep_bit);
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            step_reg  <= 4'd0;
            gnt_reg   <= 3'b000;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            led_reg   <= 8'h00;
        end else begin
            cnt_reg  <= cnt_reg + CNT_ONE;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    led_reg <= 8'h00;
                    if (|req) begin
                        state_reg <= RUN;
                        gnt_reg   <= req_sel;
                        step_reg  <= 4'd0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        led_reg   <= pat_led;
                    end
                end
                RUN: begin
                    if (preempt) begin
                        gnt_reg  <= GNT_HIT;
                        step_reg <= 4'd0;
                        cnt_reg  <= '0;
                        led_reg  <= pat_led;
                    end else if (tick) begin
                        if (step_reg == last_step) begin
                            state_reg <= GAP;
                            done_reg  <= 1'b1;
                            gnt_reg   <= 3'b000;
                            step_reg  <= 4'd0;
                            led_reg   <= 8'h00;
                        end else begin
                            step_reg <= step_reg + 4'd1;
                            led_reg  <= pat_led;
                        end
                    end
                end
                GAP: begin
                    led_reg <= 8'h00;
                    if (tick) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 3'b000;
                    busy_reg  <= 1'b0;
                    led_reg   <= 8'h00;
                end
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign led  = led_reg;

endmodule

// File: tb/tb_led_anim_sched.sv
// Self-checking bench for led_anim_sched (TICK_DIV=2): pattern table, timing sequences and a random run vs a cycle-count model.
module tb_led_anim_sched;

    localparam int TD = 2;
    localparam int SP = 1 << TD;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic       busy;
    logic       done;
    logic [7:0] led;

    led_anim_sched #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .nrst(nrst),
        .req (req),
        .gnt (gnt),
        .busy(busy),
        .done(done),
        .led (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: animation progress expressed as clock cycles since the grant.
    int m_mode;   // 0 idle, 1 running, 2 gap
    int m_anim;   // grant bit index: 0 charge, 1 hit, 2 sweep
    int m_t;
    int m_g;
    bit m_done;
    int done_cnt;

    function automatic int last_of(int a);
        if (a == 0) return 15;
        if (a == 1) return 7;
        return 13;
    endfunction

    function automatic logic [7:0] pat(int a, int s);
        logic [7:0] ones;
        logic [7:0] one;
        int k;
        int p;
        ones = 8'hFF;
        one  = 8'h01;
        if (a == 0) begin
            k = (s < 8) ? s + 1 : 16 - s;
            return ones << (8 - k);
        end
        if (a == 1) return (s % 2 == 0) ? ones : 8'h00;
        p = (s < 8) ? s : 14 - s;
        return one << p;
    endfunction

    function automatic int prio(logic [2:0] r);
        if (r[1]) return 1;
        if (r[2]) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_anim = 0; m_t = 0; m_g = 0; m_done = 0;
    endtask

    task automatic model_edge(logic [2:0] r);
        bit tk;
        bit pre;
        m_done = 0;
        case (m_mode)
            0: if (r != 3'b000) begin
                m_mode = 1; m_anim = prio(r); m_t = 0;
            end
            1: begin
                tk  = ((m_t % SP) == SP - 1);
                pre = 0;
`ifdef LED_SCHED_PREEMPT_EN
                pre = tk && r[1] && (m_anim != 1);
`endif
                if (pre) begin
                    m_anim = 1; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == (last_of(m_anim) + 1) * SP) begin
                        m_mode = 2; m_g = 0; m_done = 1;
                    end
                end
            end
            default: begin
                m_g++;
                if (m_g == SP) m_mode = 0;
            end
        endcase
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        logic [2:0] e_gnt;
        logic [7:0] e_led;
        logic [2:0] b;
        @(posedge clk);
        model_edge(req);
        #1;
        b     = 3'b001;
        e_gnt = (m_mode == 1) ? (b << m_anim) : 3'b000;
        e_led = (m_mode == 1) ? pat(m_anim, m_t / SP) : 8'h00;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("led", 32'(led), 32'(e_led));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("done", 32'(done), 32'(m_done));
        if (done) done_cnt++;
    endtask

    task automatic do_reset();
        req = 3'b000;
        nrst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        done_cnt = 0;
    endtask

    // Run until a done pulse is seen, within a cycle budget.
    task automatic wait_done(string name, int budget);
        int start;
        bit seen;
        start = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            if (done_cnt != start) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [2:0] r;
        int         step;
        logic [7:0] led;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int fd;
        int n;
        int zrun;
        int grant_cyc;
        int dones_before;
        logic [2:0] prev_gnt;
        logic [2:0] order[$];
        logic [2:0] want[3];

        vecs[0]  = '{3'b001, 0,  8'h80};
        vecs[1]  = '{3'b001, 3,  8'hF0};
        vecs[2]  = '{3'b001, 7,  8'hFF};
        vecs[3]  = '{3'b001, 8,  8'hFF};
        vecs[4]  = '{3'b001, 12, 8'hF0};
        vecs[5]  = '{3'b001, 15, 8'h80};
        vecs[6]  = '{3'b010, 0,  8'hFF};
        vecs[7]  = '{3'b010, 5,  8'h00};
        vecs[8]  = '{3'b010, 7,  8'h00};
        vecs[9]  = '{3'b100, 0,  8'h01};
        vecs[10] = '{3'b100, 7,  8'h80};
        vecs[11] = '{3'b100, 8,  8'h40};
        vecs[12] = '{3'b100, 13, 8'h02};

        model_reset();
        done_cnt = 0;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            do_reset();
            req = vecs[i].r;
            cyc();
            req = 3'b000;
            repeat (vecs[i].step * SP) cyc();
            chk("tbl_led", 32'(led), 32'(vecs[i].led));
            chk("tbl_gnt", 32'(gnt), 32'(vecs[i].r));
            $display("vec %0d req=%b step=%0d led=%h", i, vecs[i].r, vecs[i].step, led);
        end

        // Asynchronous reset in the middle of CHARGE step 5.
        do_reset();
        req = 3'b001;
        cyc();
        req = 3'b000;
        repeat (5 * SP + 1) cyc();
        chk("mid_step5_led", 32'(led), 32'hFC);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (6) cyc();
        $display("reset mid-CHARGE: gnt=%b busy=%b", gnt, busy);

        // CHARGE single pulse: done on cycle 65, exactly once.
        do_reset();
        req = 3'b001;
        fd = 0;
        for (n = 1; n <= 100; n++) begin
            cyc();
            req = 3'b000;
            if (done && fd == 0) fd = n;
        end
        chk("charge_done_cycle", 32'(fd), 32'd65);
        chk("charge_done_count", 32'(done_cnt), 32'd1);
        $display("charge pulse: done at cycle %0d count=%0d", fd, done_cnt);

        // All three requested; each requester drops after being served.
        do_reset();
        order = {};
        prev_gnt = 3'b000;
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            fd = 0;
            for (int i = 0; i < 200 && fd == 0; i++) begin
                cyc();
                if (gnt != 3'b000 && prev_gnt == 3'b000) order.push_back(gnt);
                prev_gnt = gnt;
                if (done) fd = 1;
            end
            chk("arb_done_seen", 32'(fd), 32'd1);
            if (k == 0) req = 3'b101;
            else if (k == 1) req = 3'b001;
            else req = 3'b000;
        end
        want[0] = 3'b010; want[1] = 3'b100; want[2] = 3'b001;
        chk("arb_grants", 32'(order.size()), 32'd3);
        for (int k = 0; k < 3 && k < order.size(); k++) chk("arb_order", 32'(order[k]), 32'(want[k]));
        $display("arbitration: %0d grants, done count %0d", order.size(), done_cnt);

        // HIT request arriving while CHARGE is at step 3.
        do_reset();
        req = 3'b001;
        cyc();
        req = 3'b000;
        repeat (3 * SP) cyc();
        req = 3'b010;
        grant_cyc = 0;
        dones_before = done_cnt;
        for (n = 1; n <= 100 && grant_cyc == 0; n++) begin
            cyc();
            if (gnt == 3'b010) begin
                grant_cyc = n;
                dones_before = done_cnt;
            end
        end
        req = 3'b000;
        chk("hit_led_at_grant", 32'(led), 32'hFF);
`ifdef LED_SCHED_PREEMPT_EN
        chk("preempt_cycle", 32'(grant_cyc), 32'd4);
        chk("preempt_dones", 32'(dones_before), 32'd0);
`else
        chk("nopreempt_cycle", 32'(grant_cyc), 32'd57);
        chk("nopreempt_dones", 32'(dones_before), 32'd1);
`endif
        $display("hit during charge: granted after %0d cycles, prior dones=%0d", grant_cyc, dones_before);

        // SWEEP held: back-to-back animations separated by 5 dark cycles.
        do_reset();
        req = 3'b100;
        wait_done("b2b_first_done", 200);
        for (int k = 0; k < 2; k++) begin
            zrun = 1;
            for (int i = 0; i < 20 && gnt == 3'b000; i++) begin
                cyc();
                if (gnt == 3'b000 && led == 8'h00) zrun++;
            end
            chk("b2b_gap", 32'(zrun), 32'd5);
            wait_done("b2b_done", 200);
            $display("back-to-back sweep %0d: dark cycles=%0d", k, zrun);
        end
        req = 3'b000;
        chk("b2b_done_count", 32'(done_cnt), 32'd3);

        // Randomized requests checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1999) == 0) begin
                #2;
                nrst = 1'b0;
                model_reset();
                @(negedge clk);
                nrst = 1'b1;
            end
            cyc();
        end
        $display("random run: dones=%0d", done_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
